load_store_unit: RTL and testbench

- Sits between the CPU datapath's memory-access signals (MemRead/MemWrite, ALU address, rs2 data, funct3) and the word-organised data memory.
- Converts byte/half/word loads and stores into aligned word accesses with byte-lane write enables, and sign- or zero-extends load results.
- Runs a request/ready handshake toward memory with a small FSM, so the memory may take multiple cycles; the CPU stalls on cpu_busy.

---
 rtl/load_store_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU byte/half/word accesses into aligned word accesses with a ready handshake.
// Optional watchdog on the memory handshake is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int MEM_ADDR_W     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_valid,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [2:0]            cpu_funct3,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_busy,
    output logic                  cpu_done,
    output logic                  cpu_err,
    output logic                  data_read,
    output logic                  data_write,
    output logic [MEM_ADDR_W-1:0] data_addr,
    output logic [31:0]           data_in,
    output logic [3:0]            data_web,
    input  logic [31:0]           data_out,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    generate
        if (MEM_ADDR_W < 3 || MEM_ADDR_W > 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
            $error("load_store_unit: parameter out of range");
        end
    endgenerate

    function automatic logic req_legal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        if (rd ^ wr) begin
            case (f3)
                3'b000:  ok = 1'b1;
                3'b001:  ok = (lo[0] == 1'b0);
                3'b010:  ok = (lo == 2'b00);
                3'b100:  ok = rd;
                3'b101:  ok = rd && (lo[0] == 1'b0);
                default: ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [3:0] lane_web(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] web;
        case (f3[1:0])
            2'b00:   web = 4'b0001 << lo;
            2'b01:   web = lo[1] ? 4'b1100 : 4'b0011;
            default: web = 4'b1111;
        endcase
        return web;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lo, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'h000000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_t                state_r, state_s;
    logic [2:0]            f3_r, f3_s;
    logic [1:0]            lo_r, lo_s;
    logic                  data_read_r, data_read_s;
    logic                  data_write_r, data_write_s;
    logic [MEM_ADDR_W-1:0] data_addr_r, data_addr_s;
    logic [31:0]           data_in_r, data_in_s;
    logic [3:0]            data_web_r, data_web_s;
    logic                  cpu_busy_r, cpu_busy_s;
    logic                  cpu_done_r, cpu_done_s;
    logic                  cpu_err_r, cpu_err_s;
    logic [31:0]           cpu_rdata_r, cpu_rdata_s;
`ifdef LSU_TIMEOUT_EN
    logic [7:0]            cnt_r, cnt_s;
`endif

    // Next-state and next-output decode; every output is the image of a register.
    always_comb begin
        state_s      = state_r;
        f3_s         = f3_r;
        lo_s         = lo_r;
        data_read_s  = data_read_r;
        data_write_s = data_write_r;
        data_addr_s  = data_addr_r;
        data_in_s    = data_in_r;
        data_web_s   = data_web_r;
        cpu_busy_s   = 1'b0;
        cpu_done_s   = 1'b0;
        cpu_err_s    = 1'b0;
        cpu_rdata_s  = 32'h0000_0000;
`ifdef LSU_TIMEOUT_EN
        cnt_s        = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (cpu_valid) begin
                    if (req_legal(cpu_read, cpu_write, cpu_funct3, cpu_addr[1:0])) begin
                        state_s      = ACCESS;
                        f3_s         = cpu_funct3;
                        lo_s         = cpu_addr[1:0];
                        data_read_s  = cpu_read;
                        data_write_s = cpu_write;
                        data_addr_s  = {cpu_addr[MEM_ADDR_W-1:2], 2'b00};
                        data_in_s    = cpu_write ? lane_data(cpu_funct3, cpu_wdata) : 32'h0000_0000;
                        data_web_s   = cpu_write ? lane_web(cpu_funct3, cpu_addr[1:0]) : 4'b0000;
                        cpu_busy_s   = 1'b1;
`ifdef LSU_TIMEOUT_EN
                        cnt_s        = 8'h00;
`endif
                    end else begin
                        state_s    = DONE;
                        cpu_done_s = 1'b1;
                        cpu_err_s  = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_s      = DONE;
                    cpu_done_s   = 1'b1;
                    cpu_rdata_s  = data_read_r ? load_extend(f3_r, lo_r, data_out) : 32'h0000_0000;
                    data_read_s  = 1'b0;
                    data_write_s = 1'b0;
                    data_addr_s  = '0;
                    data_in_s    = 32'h0000_0000;
                    data_web_s   = 4'b0000;
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_r == 8'(TIMEOUT_CYCLES - 1)) begin
                    // Watchdog expiry: abandon the access and report an error.
                    state_s      = DONE;
                    cpu_done_s   = 1'b1;
                    cpu_err_s    = 1'b1;
                    data_read_s  = 1'b0;
                    data_write_s = 1'b0;
                    data_addr_s  = '0;
                    data_in_s    = 32'h0000_0000;
                    data_web_s   = 4'b0000;
                end else begin
                    cnt_s      = cnt_r + 8'h01;
                    cpu_busy_s = 1'b1;
                end
`else
                end else begin
                    cpu_busy_s = 1'b1;
                end
`endif
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s      = IDLE;
                data_read_s  = 1'b0;
                data_write_s = 1'b0;
                data_addr_s  = '0;
                data_in_s    = 32'h0000_0000;
                data_web_s   = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            f3_r         <= 3'b000;
            lo_r         <= 2'b00;
            data_read_r  <= 1'b0;
            data_write_r <= 1'b0;
            data_addr_r  <= '0;
            data_in_r    <= 32'h0000_0000;
            data_web_r   <= 4'b0000;
            cpu_busy_r   <= 1'b0;
            cpu_done_r   <= 1'b0;
            cpu_err_r    <= 1'b0;
            cpu_rdata_r  <= 32'h0000_0000;
`ifdef LSU_TIMEOUT_EN
            cnt_r        <= 8'h00;
`endif
        end else begin
            state_r      <= state_s;
            f3_r         <= f3_s;
            lo_r         <= lo_s;
            data_read_r  <= data_read_s;
            data_write_r <= data_write_s;
            data_addr_r  <= data_addr_s;
            data_in_r    <= data_in_s;
            data_web_r   <= data_web_s;
            cpu_busy_r   <= cpu_busy_s;
            cpu_done_r   <= cpu_done_s;
            cpu_err_r    <= cpu_err_s;
            cpu_rdata_r  <= cpu_rdata_s;
`ifdef LSU_TIMEOUT_EN
            cnt_r        <= cnt_s;
`endif
        end
    end

    assign cpu_rdata  = cpu_rdata_r;
    assign cpu_busy   = cpu_busy_r;
    assign cpu_done   = cpu_done_r;
    assign cpu_err    = cpu_err_r;
    assign data_read  = data_read_r;
    assign data_write = data_write_r;
    assign data_addr  = data_addr_r;
    assign data_in    = data_in_r;
    assign data_web   = data_web_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, scoreboard-checked bench for load_store_unit (32-bit memory address, watchdog limit 4).
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        cpu_valid;
    logic        cpu_read;
    logic        cpu_write;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_err;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [3:0]  data_web;
    logic [31:0] data_out;
    logic        mem_ready;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rdata;
    } resp_t;

    resp_t sb_q[$];

    load_store_unit #(
        .MEM_ADDR_W    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_valid (cpu_valid),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_funct3(cpu_funct3),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_busy  (cpu_busy),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .data_read (data_read),
        .data_write(data_write),
        .data_addr (data_addr),
        .data_in   (data_in),
        .data_web  (data_web),
        .data_out  (data_out),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request, checks the memory side every ACCESS cycle, then checks the response.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                              input int ready_cycle, input int access_cycles, input logic [31:0] word,
                              input logic [31:0] exp_addr, input logic [3:0] exp_web,
                              input logic [31:0] exp_din, input logic [31:0] exp_rdata,
                              input logic exp_err, input logic chk_rdata);
        resp_t r;
        r.rdata     = exp_rdata;
        r.err       = exp_err;
        r.chk_rdata = chk_rdata;
        sb_q.push_back(r);
        cpu_valid  = 1'b1;
        cpu_read   = rd;
        cpu_write  = wr;
        cpu_funct3 = f3;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        @(negedge clk);
        for (int k = 1; k <= access_cycles; k++) begin
            check({tag, "_busy"}, {31'd0, cpu_busy}, 32'd1);
            check({tag, "_rd"}, {31'd0, data_read}, {31'd0, rd});
            check({tag, "_wr"}, {31'd0, data_write}, {31'd0, wr});
            check({tag, "_addr"}, data_addr, exp_addr);
            check({tag, "_web"}, {28'd0, data_web}, {28'd0, exp_web});
            if (wr) check({tag, "_din"}, data_in, exp_din);
            check({tag, "_early_done"}, {31'd0, cpu_done}, 32'd0);
            if (k == ready_cycle) begin
                mem_ready = 1'b1;
                data_out  = word;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            data_out  = 32'h0;
        end
        check({tag, "_done"}, {31'd0, cpu_done}, 32'd1);
        check({tag, "_busy_done"}, {31'd0, cpu_busy}, 32'd0);
        check({tag, "_strobe_done"}, {30'd0, data_read, data_write}, 32'd0);
        check({tag, "_web_done"}, {28'd0, data_web}, 32'd0);
        check({tag, "_sb_pending"}, {31'd0, (sb_q.size() != 0)}, 32'd1);
        if (sb_q.size() != 0) begin
            r = sb_q.pop_front();
            check({tag, "_err"}, {31'd0, cpu_err}, {31'd0, r.err});
            if (r.chk_rdata) check({tag, "_rdata"}, cpu_rdata, r.rdata);
        end
        cpu_valid = 1'b0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, cpu_done}, 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        cpu_valid  = 1'b0;
        cpu_read   = 1'b0;
        cpu_write  = 1'b0;
        cpu_funct3 = 3'b000;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        data_out   = 32'h0;
        mem_ready  = 1'b0;

        #2;
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_ctl", {26'd0, cpu_busy, cpu_done, cpu_err, data_read, data_write, 1'b0}, 32'd0);
        check("rst_addr", data_addr, 32'h0);
        check("rst_din", data_in, 32'h0);
        check("rst_web", {28'd0, data_web}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // mem_ready while idle must not produce a response
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("idle_ready_done", {31'd0, cpu_done}, 32'd0);
        check("idle_ready_busy", {31'd0, cpu_busy}, 32'd0);
        @(negedge clk);

        run_access("sw", 1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 3, 3, 32'h0,
                   32'h104, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        run_access("sb", 1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 1, 32'h0,
                   32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        run_access("sh", 1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 2, 2, 32'h0,
                   32'h100, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1'b0);
        run_access("lb", 1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 1, 1, 32'h80FF7F01,
                   32'h200, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
        run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 2, 2, 32'h80FF7F01,
                   32'h200, 4'b0000, 32'h0, 32'h00000080, 1'b0, 1'b1);
        run_access("lh", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 1, 1, 32'h80FF7F01,
                   32'h200, 4'b0000, 32'h0, 32'hFFFF80FF, 1'b0, 1'b1);
        run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 1, 1, 32'h80FF7F01,
                   32'h200, 4'b0000, 32'h0, 32'h00007F01, 1'b0, 1'b1);
        run_access("lw", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1, 1, 32'h80FF7F01,
                   32'h200, 4'b0000, 32'h0, 32'h80FF7F01, 1'b0, 1'b1);

        // illegal requests: no memory cycle, error response one cycle later
        run_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        run_access("lh_mis", 1'b1, 1'b0, 3'b001, 32'h201, 32'h0, 0, 0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        run_access("ld_f011", 1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        run_access("st_f100", 1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        run_access("rw_both", 1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        run_access("rw_none", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);

        // asynchronous reset in the middle of an access
        cpu_valid  = 1'b1;
        cpu_read   = 1'b0;
        cpu_write  = 1'b1;
        cpu_funct3 = 3'b010;
        cpu_addr   = 32'h104;
        cpu_wdata  = 32'hDEADBEEF;
        @(negedge clk);
        check("abort_pre_wr", {31'd0, data_write}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_wr", {31'd0, data_write}, 32'd0);
        check("abort_rd", {31'd0, data_read}, 32'd0);
        check("abort_web", {28'd0, data_web}, 32'd0);
        check("abort_busy", {31'd0, cpu_busy}, 32'd0);
        cpu_valid = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
        check("abort_no_done", {31'd0, cpu_done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_no_done2", {31'd0, cpu_done}, 32'd0);
        run_access("post_rst_lw", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 2, 2, 32'h13579BDF,
                   32'h300, 4'b0000, 32'h0, 32'h13579BDF, 1'b0, 1'b1);

`ifdef LSU_TIMEOUT_EN
        run_access("tmo", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 4, 32'h0,
                   32'h300, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        run_access("tmo_ready", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 4, 4, 32'h2468ACE0,
                   32'h300, 4'b0000, 32'h0, 32'h2468ACE0, 1'b0, 1'b1);
`endif

        check("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
